// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined, multi-cycle main memory between the
// I-cache fill path and the D-cache fill / write-through path.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transaction; sample d_req (priority) then i_req
//   ST_WRITE | single-cycle D-side write-through store
//   ST_FILL  | block fill for the latched owner: issue 8 reads, collect 8 words
//
// Reads are issued back to back while the return side counts words coming
// back from the memory pipeline, so the issue and receive counters run
// independently.  Return data is passed straight through to fill_data.

module mem_arbiter #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_req,
  input  logic [15:0] i_addr,

  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,

  output logic        i_grant,
  output logic        d_grant,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_idx,
  output logic        i_done,
  output logic        d_done,

  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdata_valid,

  output logic        busy
);

  // Block size is fixed at 8 words; the counters are one bit wider so that
  // "all issued" / "all received" is representable.
  localparam logic [3:0] BLK_CNT  = 4'(BLOCK_WORDS);
  localparam logic [3:0] LAST_IDX = 4'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner_d, owner_d_nxt;     // 1 = D side owns the transaction
  logic [14:0] addr_q, addr_nxt;         // latched byte address bits [15:1]
  logic [15:0] wdata_q, wdata_nxt;
  logic [3:0]  issue_cnt, issue_nxt;
  logic [3:0]  recv_cnt, recv_nxt;

  logic        fill_issue;
  logic        fill_recv;
  logic        fill_last;

  // Byte-lane bit 0 of the addresses is never used; the memory latency only
  // shapes the external timeline, not this controller's logic.
  logic        unused_inputs;
  assign unused_inputs = ^{i_addr[0], d_addr[0], MEM_LATENCY[0]};

  // Qualifiers for the two independent halves of a fill.
  always_comb begin
    fill_issue = 1'b0;
    fill_recv  = 1'b0;
    fill_last  = 1'b0;
    if (state == ST_FILL) begin
      fill_issue = (issue_cnt < BLK_CNT);
      // Returns beyond the last word are ignored.
      fill_recv  = mem_rdata_valid && (recv_cnt < BLK_CNT);
      fill_last  = fill_recv && (recv_cnt == LAST_IDX);
    end
  end

  // State and transaction context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      owner_d   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      owner_d   <= owner_d_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      issue_cnt <= issue_nxt;
      recv_cnt  <= recv_nxt;
    end
  end

  // Next-state, context update and all outputs.
  always_comb begin
    state_nxt    = state;
    owner_d_nxt  = owner_d;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    issue_nxt    = issue_cnt;
    recv_nxt     = recv_cnt;

    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_data    = '0;
    fill_idx     = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    busy         = (state != ST_IDLE);

    unique case (state)
      ST_IDLE: begin
        // D side has fixed priority; a losing I request simply stays pending.
        if (d_req) begin
          owner_d_nxt = 1'b1;
          addr_nxt    = d_addr[15:1];
          wdata_nxt   = d_wdata;
          issue_nxt   = '0;
          recv_nxt    = '0;
          state_nxt   = d_wr ? ST_WRITE : ST_FILL;
        end else if (i_req) begin
          owner_d_nxt = 1'b0;
          addr_nxt    = i_addr[15:1];
          wdata_nxt   = d_wdata;
          issue_nxt   = '0;
          recv_nxt    = '0;
          state_nxt   = ST_FILL;
        end
      end

      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {addr_q, 1'b0};
        mem_wdata = wdata_q;
        d_grant   = 1'b1;
        d_done    = 1'b1;
        state_nxt = ST_IDLE;
      end

      ST_FILL: begin
        if (owner_d) begin
          d_grant = 1'b1;
        end else begin
          i_grant = 1'b1;
        end

        // Issue side: one read per cycle in word order, block-aligned.
        if (fill_issue) begin
          mem_en    = 1'b1;
          mem_addr  = {addr_q[14:3], issue_cnt[2:0], 1'b0};
          issue_nxt = issue_cnt + 4'd1;
        end

        // Return side: words arrive in issue order, so the receive count
        // is the word index.
        if (fill_recv) begin
          fill_data = mem_rdata;
          fill_idx  = recv_cnt[2:0];
          recv_nxt  = recv_cnt + 4'd1;
          if (owner_d) begin
            d_fill_valid = 1'b1;
          end else begin
            i_fill_valid = 1'b1;
          end
        end

        if (fill_last) begin
          if (owner_d) begin
            d_done = 1'b1;
          end else begin
            i_done = 1'b1;
          end
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single-ported, multi-cycle unified main memory between the instruction-side and data-side cache controllers of the pipelined CPU. It services three kinds of transaction: 8-word block fills for I-cache misses, block fills for D-cache misses, and single-word D-side write-through stores. Each fill issues one pipelined read per cycle and streams the returned words, tagged with their word index, back to the owning cache.

## Interface
- `BLOCK_WORDS`, default 8: words per cache block. Fixed at 8 in this design; the word index is 3 bits.
- `MEM_LATENCY`, default 4: cycles from `mem_en` (read) to `mem_rdata_valid`.
- `clk` in 1: system clock. The block uses one clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: I-side fill request, level signal.
- `i_addr` in 16: I-side miss byte address; only bits [15:4] are used.
- `d_req` in 1: D-side request, level signal.
- `d_wr` in 1: D-side request type. 1 = single-word write, 0 = block fill.
- `d_addr` in 16: D-side byte address. Bits [15:1] are used for a write; bits [15:4] for a fill.
- `d_wdata` in 16: D-side write data.
- `i_grant` out 1: high while an I-side transaction is being serviced.
- `d_grant` out 1: high while a D-side transaction is being serviced.
- `i_fill_valid` out 1: `fill_data` and `fill_idx` are valid for the I-cache this cycle.
- `d_fill_valid` out 1: `fill_data` and `fill_idx` are valid for the D-cache this cycle.
- `fill_data` out 16: returned word, shared by both sides.
- `fill_idx` out 3: word index within the block of `fill_data`.
- `i_done` out 1: one-cycle pulse marking the end of an I-side transaction.
- `d_done` out 1: one-cycle pulse marking the end of a D-side transaction.
- `mem_en` out 1: memory access strobe.
- `mem_wr` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: memory byte address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_rdata_valid` in 1: `mem_rdata` is valid this cycle.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, WRITE, FILL.
- **IDLE, request selection.** Requests are sampled in IDLE only. Fixed priority: `d_req` wins over `i_req`. There is no preemption.
  - `d_req` with `d_wr`=1: next state is WRITE.
  - `d_req` with `d_wr`=0: next state is FILL with owner D.
  - Otherwise `i_req`: next state is FILL with owner I.
  - On entry to either state: latch the owner, latch address bits [15:1], latch `d_wdata`, and clear `issue_cnt` and `recv_cnt` (both 4 bits).
- **WRITE (1 cycle).**
  - Drive `mem_en`=1, `mem_wr`=1, `mem_addr`={latched[15:1],0}, `mem_wdata`=latched data.
  - `d_grant`=1 and `d_done`=1 in the same cycle.
  - Next state is IDLE.
- **FILL, issue side.**
  - While `issue_cnt` < 8: `mem_en`=1, `mem_wr`=0, `mem_addr`={latched[15:4], `issue_cnt`[2:0], 0}.
  - `issue_cnt` increments each cycle, so issue runs in word order 0..7.
- **FILL, return side.**
  - Each `mem_rdata_valid` cycle: `fill_data`=`mem_rdata` (combinational pass-through), `fill_idx`=`recv_cnt`[2:0], `<owner>_fill_valid`=1.
  - `recv_cnt` increments on each such cycle.
  - When the word with `recv_cnt`=7 is returned, `<owner>_done`=1 in that same cycle and the next state is IDLE.
- `<owner>_grant`=1 for every cycle spent in FILL.
- **Requester rule.** A requester holds `req`, `addr` and `data` stable until its done pulse, and clears `req` at the clock edge on which its done is high. As a result IDLE never re-grants a completed request.
- A request that loses arbitration simply stays pending and is serviced on a later IDLE cycle.
- `mem_rdata_valid` outside FILL, or with `recv_cnt`=8, is ignored: no fill_valid, no count change.
- `fill_data` and `fill_idx` are don't-care when no fill_valid is high.
- Non-owner grant, valid and done outputs are always 0.
- `mem_wdata`=0 and `mem_addr`=0 when `mem_en`=0.

## Timing
- **Reset.** Asserting `rst_n` low immediately forces:
  - state IDLE, both counters 0, latched registers 0;
  - every output 0.
  
  This holds even mid-FILL; the partial fill is abandoned and no done pulse is produced. The memory shares `rst_n` and flushes its read pipeline on reset.
- **Fill timeline.** Request seen in IDLE at cycle T:
  - grant is high from T+1;
  - issues occur at T+1..T+8;
  - data returns at T+1+L..T+8+L, where L=`MEM_LATENCY`;
  - done at T+8+L (T+12 by default);
  - IDLE at T+13, earliest next grant at T+14.
- **Write timeline.** Request at cycle T: write issued and done at T+1; IDLE at T+2.
- **Simultaneous requests.** When D and I request in the same IDLE cycle, D is serviced and I waits in full. Lowering `i_req` while it is waiting is a protocol violation.

## Test plan
- **Single I fill.** `i_req` at T with `i_addr`=0x1236.
  - `mem_addr` 0x1230, 0x1232, ..., 0x123E at T+1..T+8.
  - Eight `i_fill_valid` pulses with `fill_idx` 0..7 at T+5..T+12.
  - `i_done` at T+12 only; `d_*` outputs stay 0.
- **D write.** `d_req`=1, `d_wr`=1, `d_addr`=0x0042, `d_wdata`=0xBEEF.
  - At T+1: `mem_en`=1, `mem_wr`=1, `mem_addr`=0x0042, `mem_wdata`=0xBEEF, `d_done`=1.
  - `busy` returns to 0 at T+2.
- **Simultaneous requests.** D fill (0x2000) and I fill (0x0100) requested at T.
  - D is issued T+1..T+8 and `d_done` fires at T+12.
  - I is granted at T+14, with `mem_addr` 0x0100 at T+14; `i_done` at T+25.
- **D write arrives during an I fill.** `d_req` write raised at T+3 while an I fill is in progress.
  - No memory write occurs before T+13.
  - Write is issued at T+14.
  - The I fill data order is unchanged.
- **Reset mid-fill.** Drop `rst_n` at T+6 of an I fill.
  - All outputs are 0 in that same cycle.
  - No `i_done` is produced.
  - After release, a stray `mem_rdata_valid` in IDLE produces no fill_valid.
  - A new `i_req` then completes normally with 8 words.
- **Back-to-back I fills.** Requester re-raises `i_req` with a new address at the edge after done.
  - Second grant at the done cycle + 2.
  - `fill_idx` restarts at 0.
